// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding imem handshake,
// and owns the IF/ID register with a one-entry hold buffer for ID back-pressure.
module if_fetch_unit #(
    parameter int              BUS_W    = 32,
    parameter logic [BUS_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [BUS_W-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallIFIn,
    input  logic             redirectIn,
    input  logic [BUS_W-1:0] redirectPcIn,
    output logic             imemReqOut,
    output logic [BUS_W-1:0] imemAddrOut,
    input  logic             imemAckIn,
    input  logic [BUS_W-1:0] imemDataIn,
    output logic [BUS_W-1:0] instOut_IFID,
    output logic [BUS_W-1:0] pcOut_IFID,
    output logic             validOut_IFID
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    localparam logic [BUS_W-1:0] WORD_STEP  = BUS_W'(4);
    localparam logic [BUS_W-1:0] ALIGN_MASK = ~BUS_W'(3);

    function automatic logic [BUS_W-1:0] word_align(input logic [BUS_W-1:0] a);
        return a & ALIGN_MASK;
    endfunction

    state_t           state, state_n;
    logic [BUS_W-1:0] pc_next, pc_next_n;
    logic [BUS_W-1:0] addr_n;
    logic [BUS_W-1:0] buf_inst, buf_inst_n;
    logic [BUS_W-1:0] buf_pc, buf_pc_n;
    logic [BUS_W-1:0] inst_n, pc_n;
    logic             vld_n;
    logic             ack;
    logic [BUS_W-1:0] target;

    // Request is a pure function of state so an async reset drops it at once.
    assign imemReqOut = (state == S_REQ) || (state == S_DROP);
    assign ack        = imemAckIn && imemReqOut;
    assign target     = word_align(redirectPcIn);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_BOOT;
            pc_next       <= RESET_PC;
            imemAddrOut   <= RESET_PC;
            buf_inst      <= '0;
            buf_pc        <= '0;
            instOut_IFID  <= NOP_INST;
            pcOut_IFID    <= '0;
            validOut_IFID <= 1'b0;
        end else begin
            state         <= state_n;
            pc_next       <= pc_next_n;
            imemAddrOut   <= addr_n;
            buf_inst      <= buf_inst_n;
            buf_pc        <= buf_pc_n;
            instOut_IFID  <= inst_n;
            pcOut_IFID    <= pc_n;
            validOut_IFID <= vld_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_next_n  = pc_next;
        addr_n     = imemAddrOut;
        buf_inst_n = buf_inst;
        buf_pc_n   = buf_pc;
        inst_n     = instOut_IFID;
        pc_n       = pcOut_IFID;
        vld_n      = validOut_IFID;

        if (redirectIn) begin
            inst_n     = NOP_INST;
            pc_n       = '0;
            vld_n      = 1'b0;
            pc_next_n  = target;
            buf_inst_n = '0;
            buf_pc_n   = '0;
            case (state)
                S_REQ: begin
                    if (ack) begin
                        addr_n  = target;
                        state_n = S_REQ;
                    end else begin
                        // The stale request must still complete; its data is dropped.
                        state_n = S_DROP;
                    end
                end
                S_DROP: state_n = S_DROP;
                default: begin
                    addr_n  = target;
                    state_n = S_REQ;
                end
            endcase
        end else begin
            // ID consumes IF/ID every unstalled cycle, so it empties unless refilled.
            if (!stallIFIn) begin
                inst_n = NOP_INST;
                pc_n   = '0;
                vld_n  = 1'b0;
            end
            case (state)
                S_BOOT: begin
                    addr_n  = pc_next;
                    state_n = S_REQ;
                end
                S_REQ: begin
                    if (ack) begin
                        if (stallIFIn) begin
                            buf_inst_n = imemDataIn;
                            buf_pc_n   = imemAddrOut;
                            state_n    = S_HOLD;
                        end else begin
                            inst_n = imemDataIn;
                            pc_n   = imemAddrOut;
                            vld_n  = 1'b1;
                            addr_n = imemAddrOut + WORD_STEP;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stallIFIn) begin
                        inst_n  = buf_inst;
                        pc_n    = buf_pc;
                        vld_n   = 1'b1;
                        addr_n  = buf_pc + WORD_STEP;
                        state_n = S_REQ;
                    end
                end
                S_DROP: begin
                    if (ack) begin
                        addr_n  = pc_next;
                        state_n = S_REQ;
                    end
                end
                default: state_n = S_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a wait-state imem model returns addr+TAG,
// and each cycle's outputs are compared against hand-derived values.
module tb_if_fetch_unit;

    localparam int          BUS_W = 32;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] TAG   = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        req;
    logic [31:0] addr;
    logic        ack = 1'b0;
    logic [31:0] data = '0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;

    int vectors = 0;
    int miscompares = 0;
    int mem_wait = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .BUS_W   (BUS_W),
        .RESET_PC(32'h0000_0000),
        .NOP_INST(NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallIFIn    (stall),
        .redirectIn   (redir),
        .redirectPcIn (redir_pc),
        .imemReqOut   (req),
        .imemAddrOut  (addr),
        .imemAckIn    (ack),
        .imemDataIn   (data),
        .instOut_IFID (inst),
        .pcOut_IFID   (pc),
        .validOut_IFID(valid)
    );

    // Memory: acks after mem_wait idle cycles of an asserted request.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!req) begin
                ack = 1'b0;
                cnt = 0;
            end else if (cnt == mem_wait) begin
                ack  = 1'b1;
                data = addr + TAG;
                cnt  = 0;
            end else begin
                ack = 1'b0;
                cnt = cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors = vectors + 1;
        if (got !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_ifid(input string tag, input logic v, input logic [31:0] p);
        check({tag, ".valid"}, {31'd0, valid}, {31'd0, v});
        check({tag, ".pc"}, pc, p);
        check({tag, ".inst"}, inst, v ? p + TAG : NOP);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a;

        // Reset state
        repeat (2) tick();
        check("rst.req", {31'd0, req}, 32'd0);
        check("rst.addr", addr, 32'h0);
        check_ifid("rst.ifid", 1'b0, 32'h0);

        // Boot: first request in the second cycle after release
        rst = 1'b1;
        check("boot.req0", {31'd0, req}, 32'd0);
        tick();
        check("boot.req1", {31'd0, req}, 32'd1);
        check("boot.addr", addr, 32'h0);
        check_ifid("boot.ifid", 1'b0, 32'h0);

        // Zero-wait streaming
        for (int i = 0; i < 4; i++) begin
            tick();
            check_ifid("zw.ifid", 1'b1, 32'(4 * i));
            check("zw.addr", addr, 32'(4 * (i + 1)));
            check("zw.req", {31'd0, req}, 32'd1);
        end

        // Stall across the ack of 0x10
        stall = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            check("stall.req", {31'd0, req}, 32'd0);
            check_ifid("stall.ifid", 1'b1, 32'h0C);
        end
        stall = 1'b0;
        tick();
        check_ifid("unstall.ifid", 1'b1, 32'h10);
        check("unstall.addr", addr, 32'h14);
        check("unstall.req", {31'd0, req}, 32'd1);
        tick();
        check_ifid("unstall2.ifid", 1'b1, 32'h14);
        check("unstall2.addr", addr, 32'h18);

        // Two wait states: request stable three cycles per fetch
        mem_wait = 2;
        for (int f = 0; f < 2; f++) begin
            a = 32'h18 + 32'(4 * f);
            for (int w = 0; w < 2; w++) begin
                tick();
                check("w2.addr", addr, a);
                check("w2.req", {31'd0, req}, 32'd1);
                check_ifid("w2.bubble", 1'b0, 32'h0);
            end
            tick();
            check_ifid("w2.ifid", 1'b1, a);
            check("w2.next", addr, a + 32'd4);
        end

        // Asynchronous reset mid-fetch
        tick();
        check("midrst.pre", addr, 32'h20);
        #2;
        rst = 1'b0;
        #1;
        check("midrst.req", {31'd0, req}, 32'd0);
        check("midrst.addr", addr, 32'h0);
        check_ifid("midrst.ifid", 1'b0, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("restart.req", {31'd0, req}, 32'd1);
        check("restart.addr", addr, 32'h0);
        for (int f = 0; f < 2; f++) begin
            a = 32'(4 * f);
            for (int w = 0; w < 2; w++) begin
                tick();
                check("rs.addr", addr, a);
                check_ifid("rs.bubble", 1'b0, 32'h0);
            end
            tick();
            check_ifid("rs.ifid", 1'b1, a);
            check("rs.next", addr, a + 32'd4);
        end

        // Redirect to 0x203 while the fetch of 0x8 is outstanding
        tick();
        check("drop.pre", addr, 32'h8);
        redir = 1'b1;
        redir_pc = 32'h203;
        tick();
        redir = 1'b0;
        check_ifid("drop.bubble", 1'b0, 32'h0);
        check("drop.addr", addr, 32'h8);
        check("drop.req", {31'd0, req}, 32'd1);
        tick();
        check_ifid("drop.discard", 1'b0, 32'h0);
        check("drop.target", addr, 32'h200);
        check("drop.req2", {31'd0, req}, 32'd1);
        for (int w = 0; w < 2; w++) begin
            tick();
            check_ifid("drop.wait", 1'b0, 32'h0);
            check("drop.waddr", addr, 32'h200);
        end
        tick();
        check_ifid("drop.ifid", 1'b1, 32'h200);
        check("drop.next", addr, 32'h204);

        // Redirect coincident with ack and stall: buffer must not take the old data
        mem_wait = 0;
        redir = 1'b1;
        redir_pc = 32'h300;
        stall = 1'b1;
        tick();
        redir = 1'b0;
        check_ifid("coin.bubble", 1'b0, 32'h0);
        check("coin.addr", addr, 32'h300);
        check("coin.req", {31'd0, req}, 32'd1);
        tick();
        check("coin.hold", {31'd0, req}, 32'd0);
        check_ifid("coin.held", 1'b0, 32'h0);
        stall = 1'b0;
        tick();
        check_ifid("coin.ifid", 1'b1, 32'h300);
        check("coin.next", addr, 32'h304);
        tick();
        check_ifid("coin.ifid2", 1'b1, 32'h304);
        check("coin.next2", addr, 32'h308);

        // Address wrap at the top of memory
        redir = 1'b1;
        redir_pc = 32'hFFFF_FFFE;
        tick();
        redir = 1'b0;
        check_ifid("wrap.bubble", 1'b0, 32'h0);
        check("wrap.addr", addr, 32'hFFFF_FFFC);
        tick();
        check_ifid("wrap.ifid", 1'b1, 32'hFFFF_FFFC);
        check("wrap.next", addr, 32'h0);
        tick();
        check_ifid("wrap.ifid2", 1'b1, 32'h0);
        check("wrap.next2", addr, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage for the RVX five-stage pipeline: owns the PC, drives a single-outstanding-request instruction-memory handshake, and owns the IF/ID pipeline register. It sits on the consuming end of the hazard/forwarding unit: it obeys that unit's IF stall and the EX-stage branch/jump redirect. Instructions are delivered to ID with their PC and a valid bit. When ID cannot accept a fetched instruction, the instruction is held in a one-entry buffer instead of being refetched.

## Interface
- BUS_W, 32, data/address width (matches `BUS_W`)
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0) loaded into IF/ID when empty or flushed
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- stallIFIn  in  1  hazard unit load-use stall; hold PC and IF/ID
- redirectIn  in  1  EX-stage taken branch/jump; one-cycle pulse
- redirectPcIn  in  BUS_W  redirect target; bits [1:0] ignored (treated as 00)
- imemReqOut  out  1  fetch request
- imemAddrOut  out  BUS_W  fetch address, registered, word aligned
- imemAckIn  in  1  memory completion; data valid this cycle
- imemDataIn  in  BUS_W  fetched instruction
- instOut_IFID  out  BUS_W  instruction to ID
- pcOut_IFID  out  BUS_W  PC of instOut_IFID
- validOut_IFID  out  1  IF/ID holds a real instruction

## Operation
- Handshake: once imemReqOut rises, imemReqOut and imemAddrOut stay stable until the cycle imemAckIn=1 (inclusive). imemAckIn is ignored while imemReqOut=0. Ack may arrive in the same cycle as the request (zero-wait).
- Registers: pcNext (next address to fetch), imemAddrOut, one-entry buffer (bufInst, bufPc), IF/ID (inst, pc, valid), 2-bit state.
- States:
  - S_BOOT: req=0. Next cycle imemAddrOut<=pcNext, go S_REQ.
  - S_REQ: req=1.
    - On ack with no stall and no redirect: IF/ID<={imemDataIn, imemAddrOut, 1}; imemAddrOut<=imemAddrOut+4; stay S_REQ.
    - On ack with stallIFIn=1: bufInst/bufPc capture the data and address; go S_HOLD, req=0.
  - S_HOLD: req=0. When stallIFIn=0: IF/ID<=buffer (valid=1); imemAddrOut<=bufPc+4; go S_REQ.
  - S_DROP: req=1 with the stale address. On ack: discard data; imemAddrOut<=pcNext (redirect target); go S_REQ.
- Redirect has priority over stall and normal update, in any state:
  - IF/ID<={NOP_INST, 0, 0}; pcNext<={redirectPcIn[BUS_W-1:2],2'b00}; buffer contents discarded.
  - S_REQ without ack this cycle: go S_DROP.
  - S_REQ with ack this cycle, S_HOLD, or S_BOOT: imemAddrOut<=target; go S_REQ.
  - Redirect in S_DROP: update pcNext only; remain in S_DROP.
- Stall without redirect: IF/ID holds its value, including a bubble.
- Address arithmetic is modulo 2^BUS_W; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset (async assert): state=S_BOOT, imemReqOut=0, imemAddrOut=RESET_PC, pcNext=RESET_PC, instOut_IFID=NOP_INST, pcOut_IFID=0, validOut_IFID=0, buffer cleared.
- First imemReqOut=1 occurs in the second cycle after rst deasserts.
- Zero-wait memory: one instruction enters IF/ID per cycle. Fetch-to-IF/ID latency is 1 edge after ack.
- N wait-state memory: one instruction per N+1 cycles.
- Redirect penalty: IF/ID is a bubble the cycle after redirect. The target reaches IF/ID at the earliest 1 edge after its ack.
- Reset asserted mid-request drops the request immediately (imemReqOut=0 asynchronously). The bench must not expect completion of that request.

## Test plan
- Reset, zero-wait memory returning addr-as-data -> imemAddrOut 0,4,8,…; IF/ID pc 0,4,8 on consecutive cycles with valid=1; first req in 2nd cycle after reset.
- 2-wait-state memory -> req/addr stable 3 cycles per fetch; IF/ID updates every 3 cycles.
- stallIFIn high 3 cycles while ack of addr 0x10 arrives -> S_HOLD, req=0; IF/ID unchanged; after release IF/ID pc=0x10, next req addr=0x14.
- redirectIn to 0x203 while 2-wait fetch of 0x8 outstanding -> IF/ID bubble next cycle; req stays on 0x8 until ack; data discarded; next req addr=0x200; no 0x8 instruction ever valid.
- redirect coincident with ack and with stallIFIn -> bubble; buffer not loaded; next req addr=target.
- rst low mid-fetch -> all outputs at reset values that cycle; restart from RESET_PC.
